bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Shares one single-port block RAM between the CPU's instruction-fetch port and data-memory port, so the MIPS core can run from a unified memory. It sits between the core and the RAM, and serialises accesses with a registered, one-outstanding-transaction FSM. It returns read data and ready pulses to each port. Data accesses normally take priority; a starvation counter guarantees that fetch eventually wins.

## Interface
- AW, 32, address width
- DW, 32, data width
- RD_LAT, 1, RAM read latency in cycles (1..4), counted from the mem_en cycle
- STARVE_MAX, 4, consecutive lost arbitrations before instruction port is forced to win
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, held until i_ready
- i_addr  in  AW  fetch byte address
- i_rdata  out  DW  fetch data, valid while i_ready=1
- i_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, held until d_ready
- d_we  in  4  byte write enables; 4'b0000 means read
- d_addr  in  AW  data byte address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- mem_en  out  1  RAM enable
- mem_we  out  4  RAM byte write enables
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE
  - if neither request is high, stay in IDLE.
  - otherwise choose a winner, register its addr/we/wdata into the mem_* registers and go to ACCESS.
- ACCESS: mem_en=1 for exactly one cycle.
  - read: load lat_cnt=RD_LAT and go to WAIT.
  - write: go to RESP.
- WAIT: decrement lat_cnt each cycle. When lat_cnt reaches 1, capture mem_rdata into the winner's rdata register and go to RESP.
- RESP: assert the winner's ready for one cycle, then go to IDLE.
- Arbitration:
  - only d_req high: data wins.
  - only i_req high: instruction wins.
  - both high: data wins, unless starve_cnt==STARVE_MAX, in which case instruction wins.
- starve_cnt:
  - increments (saturating at STARVE_MAX) each IDLE arbitration in which i_req is high and data wins.
  - clears when instruction is granted or i_req is low in IDLE.
- mem_en, mem_we and ready are deasserted outside their states.
- mem_addr and mem_wdata hold their last values.
- rdata registers hold their last value between transactions.
- Fetches always drive mem_we=0.
- Requests sampled outside IDLE are ignored.
- Requester contract: after ready, drop req or present a new request. The arbiter samples again in IDLE, one cycle after RESP.
- Reset, including mid-transaction:
  - state returns to IDLE and starve_cnt to 0.
  - all outputs go to 0.
  - the in-flight transaction is dropped and no ready is issued; requesters must reissue.

## Timing
- Request sampled in IDLE at cycle 0 → ACCESS in cycle 1.
- Read ready: cycle 2+RD_LAT (RD_LAT=1 gives cycle 3).
- Write ready: cycle 2.
- RAM write occurs in the ACCESS cycle.
- Max throughput: one write per 3 cycles, one read per 3+RD_LAT cycles.
- Both requests high in the same IDLE cycle: the loser waits for the full winner transaction plus return to IDLE.
- Worst-case fetch wait with continuous data traffic: STARVE_MAX data transactions, then fetch is granted.
- Outputs are all registered or state-decoded; there is no combinational path from req to mem_*.

## Structure
- Shared package `bram_arb_pkg`:
  - state encoding localparams IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3.
  - grant encoding GNT_I=1'b0, GNT_D=1'b1.
- One sub-module, `arb_starve_ctr`: saturating counter with inc/clr inputs and an at_max output, width clog2(STARVE_MAX+1).
- The FSM, latency counter and datapath registers live in the top `bram_arbiter`.

## Test plan
- Reset check: hold rst=0 mid-ACCESS → all outputs 0 next edge; after release busy=0 and no stale ready.
- Single read, RD_LAT=1:
  - stimulus: i_req=1, i_addr=0x40, RAM returns 0x2402_0005.
  - response: mem_en in cycle 1 with mem_addr=0x40, i_ready with i_rdata=0x2402_0005 in cycle 3.
- Single store:
  - stimulus: d_req=1, d_we=4'b0011, d_addr=0x80, d_wdata=0xDEAD_BEEF.
  - response: mem_en=1 and mem_we=4'b0011 in cycle 1, d_ready in cycle 2, i_ready stays 0.
- Simultaneous requests:
  - stimulus: both high at cycle 0.
  - response: data served first (d_ready cycle 3), instruction granted at the next IDLE, i_ready 3 cycles later.
- Starvation:
  - stimulus: i_req held high, d_req re-asserted continuously, STARVE_MAX=4.
  - response: exactly 4 data grants, then an instruction grant, then starve_cnt=0.
- Latency sweep:
  - stimulus: RD_LAT=3, data read of 0x100 returning 0x1234_5678.
  - response: d_ready in cycle 5 with d_rdata=0x1234_5678, mem_en high only in cycle 1.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the unified instruction/data BRAM arbiter.
// Holds the FSM state encoding, the grant encoding and the arbitration rule.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_t;

    // Wide enough to hold the largest supported read latency (4).
    localparam int LAT_W = 3;

    // Data wins by default; a starved fetch port overrides it.
    function automatic arb_gnt_t pick_winner(logic i_req, logic d_req, logic starved);
        if (i_req && (!d_req || starved)) begin
            return GNT_I;
        end
        return GNT_D;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive arbitrations the fetch port has lost.
// at_max tells the arbiter to hand the next contested grant to fetch.
module arb_starve_ctr #(
    parameter  int MAX = 4,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Serialises fetch and data accesses onto one single-port block RAM with a
// one-outstanding-transaction FSM; all RAM-side and ready outputs are registered.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic [3:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT);

    arb_state_t       state;
    arb_gnt_t         gnt;
    arb_gnt_t         winner;
    logic [LAT_W-1:0] lat_cnt;
    logic             starved;
    logic             starve_inc;
    logic             starve_clr;

    assign busy = (state != IDLE);

    // NOTE: every signal written here gets a default before any condition, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        winner     = pick_winner(i_req, d_req, starved);
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        if (state == IDLE) begin
            if (i_req && (winner == GNT_D)) begin
                starve_inc = 1'b1;
            end else begin
                starve_clr = 1'b1;
            end
        end
    end

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starved)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= GNT_I;
            lat_cnt   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            // Strobes are single-cycle; only the branch entering their state re-raises them.
            mem_en  <= 1'b0;
            mem_we  <= '0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        gnt    <= winner;
                        mem_en <= 1'b1;
                        state  <= ACCESS;
                        if (winner == GNT_D) begin
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_addr  <= i_addr;
                        end
                    end
                end

                ACCESS: begin
                    if (mem_we == 4'b0000) begin
                        lat_cnt <= LAT_INIT;
                        state   <= WAIT;
                    end else begin
                        i_ready <= (gnt == GNT_I);
                        d_ready <= (gnt == GNT_D);
                        state   <= RESP;
                    end
                end

                WAIT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (lat_cnt == LAT_W'(1)) begin
                        if (gnt == GNT_I) begin
                            i_rdata <= mem_rdata;
                            i_ready <= 1'b1;
                        end else begin
                            d_rdata <= mem_rdata;
                            d_ready <= 1'b1;
                        end
                        state <= RESP;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: two instances (read latency 1 and 3) share one
// clock; fetches use addresses below 0x80, data accesses use 0x80..0x1FC.
module tb_bram_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
    localparam int LAT0       = 1;
    localparam int LAT1       = 3;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          i_req     [2];
    logic [AW-1:0] i_addr    [2];
    logic [DW-1:0] i_rdata   [2];
    logic          i_ready   [2];
    logic          d_req     [2];
    logic [3:0]    d_we      [2];
    logic [AW-1:0] d_addr    [2];
    logic [DW-1:0] d_wdata   [2];
    logic [DW-1:0] d_rdata   [2];
    logic          d_ready   [2];
    logic          mem_en    [2];
    logic [3:0]    mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];
    logic          busy      [2];

    logic [31:0] pipe    [2][4];
    logic [31:0] ram     [2][128];
    bit          ram_init = 1'b0;
    logic [31:0] ref_mem [2][128];
    txn_t        iq [2][$];
    txn_t        dq [2][$];

    int checks = 0;
    int errors = 0;

    int          w_en_first, w_en_cnt, w_ir_first, w_ir_cnt, w_dr_first, w_dr_cnt;
    logic [31:0] w_addr, w_wdata;
    logic [3:0]  w_we;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = (k == 0) ? LAT0 : LAT1;
        bram_arbiter #(
            .AW(AW), .DW(DW), .RD_LAT(LAT), .STARVE_MAX(STARVE_MAX)
        ) u_dut (
            .clk(clk), .rst(rst),
            .i_req(i_req[k]), .i_addr(i_addr[k]), .i_rdata(i_rdata[k]), .i_ready(i_ready[k]),
            .d_req(d_req[k]), .d_we(d_we[k]), .d_addr(d_addr[k]), .d_wdata(d_wdata[k]),
            .d_rdata(d_rdata[k]), .d_ready(d_ready[k]),
            .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
            .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k]), .busy(busy[k])
        );
        assign mem_rdata[k] = pipe[k][LAT-1];
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [31:0] init_word(input int k, input int idx);
        if (idx == 'h10) return 32'h2402_0005;
        if (idx == 'h40) return 32'h1234_5678;
        return (32'(idx) * 32'h9E37_79B1) ^ (32'(k) << 28) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // RAM model: byte-enabled write in the enable cycle, read data RD_LAT cycles later.
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 128; i++) ram[k][i] = init_word(k, i);
            ram_init = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            for (int s = 3; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
            if (mem_en[k]) begin
                pipe[k][0] <= ram[k][mem_addr[k][8:2]];
                if (mem_we[k] != 4'b0000)
                    ram[k][mem_addr[k][8:2]] = merge(ram[k][mem_addr[k][8:2]], mem_wdata[k], mem_we[k]);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string got, input string req);
        checks++;
        errors++;
        $display("FAIL %s: got %s, required %s", name, got, req);
    endtask

    task automatic check_zero(input int k, input string tag);
        check($sformatf("k%0d %s ctl", k, tag),
              {mem_en[k], mem_we[k], i_ready[k], d_ready[k], busy[k]}, 0);
        check($sformatf("k%0d %s addr/wdata", k, tag), {mem_addr[k], mem_wdata[k]}, 0);
        check($sformatf("k%0d %s rdata", k, tag), {i_rdata[k], d_rdata[k]}, 0);
    endtask

    task automatic issue_fetch(input int k, input logic [31:0] a);
        txn_t t;
        t.addr  = a;
        t.we    = 4'b0000;
        t.wdata = '0;
        t.rdata = ref_mem[k][a[8:2]];
        iq[k].push_back(t);
        i_addr[k] = a;
        i_req[k]  = 1'b1;
    endtask

    task automatic issue_data(input int k, input logic [31:0] a, input logic [3:0] we,
                              input logic [31:0] wd);
        txn_t t;
        t.addr  = a;
        t.we    = we;
        t.wdata = wd;
        t.rdata = ref_mem[k][a[8:2]];
        if (we != 4'b0000) ref_mem[k][a[8:2]] = merge(ref_mem[k][a[8:2]], wd, we);
        dq[k].push_back(t);
        d_addr[k]  = a;
        d_we[k]    = we;
        d_wdata[k] = wd;
        d_req[k]   = 1'b1;
    endtask

    // Pops the expected transaction whenever a ready appears and checks the RAM side.
    task automatic monitor();
        logic prev_en [2];
        txn_t t;
        prev_en[0] = 1'b0;
        prev_en[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (mem_en[k]) begin
                    check($sformatf("k%0d busy in access", k), busy[k], 1);
                    check($sformatf("k%0d mem_en one cycle", k), prev_en[k], 0);
                    if (mem_addr[k] < 32'h80) begin
                        if (iq[k].size() == 0)
                            fail_now($sformatf("k%0d fetch access", k), "access", "no fetch pending");
                        else begin
                            check($sformatf("k%0d fetch mem_addr", k), mem_addr[k], iq[k][0].addr);
                            check($sformatf("k%0d fetch mem_we", k), mem_we[k], 0);
                        end
                    end else begin
                        if (dq[k].size() == 0)
                            fail_now($sformatf("k%0d data access", k), "access", "no data pending");
                        else begin
                            check($sformatf("k%0d data mem_addr", k), mem_addr[k], dq[k][0].addr);
                            check($sformatf("k%0d data mem_we", k), mem_we[k], dq[k][0].we);
                            if (dq[k][0].we != 4'b0000)
                                check($sformatf("k%0d data mem_wdata", k), mem_wdata[k], dq[k][0].wdata);
                        end
                    end
                end
                prev_en[k] = mem_en[k];
                if (i_ready[k] && d_ready[k])
                    fail_now($sformatf("k%0d ready overlap", k), "both readies", "at most one");
                if (i_ready[k]) begin
                    if (iq[k].size() == 0)
                        fail_now($sformatf("k%0d i_ready", k), "unexpected pulse", "none");
                    else begin
                        t = iq[k].pop_front();
                        check($sformatf("k%0d i_rdata @%0h", k, t.addr), i_rdata[k], t.rdata);
                    end
                end
                if (d_ready[k]) begin
                    if (dq[k].size() == 0)
                        fail_now($sformatf("k%0d d_ready", k), "unexpected pulse", "none");
                    else begin
                        t = dq[k].pop_front();
                        if (t.we == 4'b0000)
                            check($sformatf("k%0d d_rdata @%0h", k, t.addr), d_rdata[k], t.rdata);
                    end
                end
            end
        end
    endtask

    // Records event cycles relative to the issuing negedge; drops requests on ready.
    task automatic watch(input int k, input int n);
        w_en_first = -1; w_en_cnt = 0;
        w_ir_first = -1; w_ir_cnt = 0;
        w_dr_first = -1; w_dr_cnt = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (mem_en[k]) begin
                if (w_en_first < 0) begin
                    w_en_first = c;
                    w_addr     = mem_addr[k];
                    w_we       = mem_we[k];
                    w_wdata    = mem_wdata[k];
                end
                w_en_cnt++;
            end
            if (i_ready[k]) begin
                if (w_ir_first < 0) w_ir_first = c;
                w_ir_cnt++;
                i_req[k] = 1'b0;
            end
            if (d_ready[k]) begin
                if (w_dr_first < 0) w_dr_first = c;
                w_dr_cnt++;
                d_req[k] = 1'b0;
            end
        end
    endtask

    task automatic wait_ready(input int k, input bit port_d, input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (port_d ? d_ready[k] : i_ready[k]) begin
                lat = c;
                break;
            end
        end
        if (lat < 0)
            fail_now($sformatf("k%0d %s ready timeout", k, port_d ? "data" : "fetch"), "no ready", "ready");
    endtask

    task automatic run_fetch(input int k, input int n);
        int lat;
        logic [31:0] a;
        for (int j = 0; j < n; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = 32'($urandom_range(0, 31)) << 2;
            issue_fetch(k, a);
            wait_ready(k, 1'b0, 200, lat);
            i_req[k] = 1'b0;
            if (lat > 0)
                check($sformatf("k%0d fetch wait %0d within bound", k, lat),
                      lat <= (STARVE_MAX + 2) * (3 + lat_of(k)), 1);
        end
    endtask

    task automatic run_data(input int k, input int n);
        int lat;
        logic [31:0] a;
        logic [3:0]  we;
        for (int j = 0; j < n; j++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a  = 32'h80 + (32'($urandom_range(0, 95)) << 2);
            we = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            issue_data(k, a, we, $urandom());
            wait_ready(k, 1'b1, 200, lat);
            d_req[k] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dcount;
        int fetches;
        bit done;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 128; i++) ref_mem[k][i] = init_word(k, i);
            i_req[k] = 1'b0; i_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        #1 rst = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check_zero(0, "reset");
        check_zero(1, "reset");
        rst = 1'b1;
        @(negedge clk);

        // Single fetch, latency 1.
        issue_fetch(0, 32'h40);
        watch(0, 6);
        check("fetch mem_en cycle", w_en_first, 1);
        check("fetch mem_addr", w_addr, 32'h40);
        check("fetch mem_we", w_we, 0);
        check("fetch i_ready cycle", w_ir_first, 3);
        check("fetch i_ready count", w_ir_cnt, 1);
        check("fetch mem_en count", w_en_cnt, 1);

        // Single store, then read it back through the scoreboard.
        issue_data(0, 32'h80, 4'b0011, 32'hDEAD_BEEF);
        watch(0, 5);
        check("store mem_en cycle", w_en_first, 1);
        check("store mem_we", w_we, 4'b0011);
        check("store mem_addr", w_addr, 32'h80);
        check("store mem_wdata", w_wdata, 32'hDEAD_BEEF);
        check("store d_ready cycle", w_dr_first, 2);
        check("store i_ready count", w_ir_cnt, 0);
        issue_data(0, 32'h80, 4'b0000, 32'h0);
        watch(0, 6);
        check("readback d_ready cycle", w_dr_first, 3);

        // Simultaneous requests: data first, fetch after the next IDLE.
        issue_data(0, 32'h100, 4'b0000, 32'h0);
        issue_fetch(0, 32'h44);
        watch(0, 10);
        check("simul first access addr", w_addr, 32'h100);
        check("simul d_ready cycle", w_dr_first, 3);
        check("simul i_ready cycle", w_ir_first, 7);
        check("simul mem_en count", w_en_cnt, 2);

        // Starvation: continuous data traffic, fetch re-requested after each grant.
        issue_fetch(0, 32'h48);
        issue_data(0, 32'h180, 4'b1111, $urandom());
        dcount  = 0;
        fetches = 0;
        done    = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (d_ready[0]) begin
                dcount++;
                if (fetches < 2)
                    issue_data(0, 32'h80 + (32'($urandom_range(0, 95)) << 2), 4'b1111, $urandom());
                else
                    d_req[0] = 1'b0;
            end
            if (i_ready[0]) begin
                fetches++;
                check($sformatf("starve data grants before fetch %0d", fetches), dcount, STARVE_MAX);
                dcount = 0;
                if (fetches < 2) issue_fetch(0, 32'h4C);
                else i_req[0] = 1'b0;
            end
            if (fetches == 2 && !d_req[0]) done = 1'b1;
        end
        if (!done) begin
            fail_now("starvation sequence", "incomplete", "two fetch grants");
            i_req[0] = 1'b0;
            d_req[0] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("starve idle busy", busy[0], 0);

        // Latency sweep on the RD_LAT=3 instance.
        issue_data(1, 32'h100, 4'b0000, 32'h0);
        watch(1, 8);
        check("lat3 d_ready cycle", w_dr_first, 5);
        check("lat3 mem_en cycle", w_en_first, 1);
        check("lat3 mem_en count", w_en_cnt, 1);

        // Reset while a fetch is in ACCESS.
        issue_fetch(0, 32'h50);
        @(negedge clk);
        check("reset test in access", mem_en[0], 1);
        #2 rst = 1'b0;
        #1 check_zero(0, "mid-access reset");
        i_req[0] = 1'b0;
        iq[0].delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        watch(0, 6);
        check("post-reset i_ready count", w_ir_cnt, 0);
        check("post-reset mem_en count", w_en_cnt, 0);
        check("post-reset busy", busy[0], 0);

        // Randomised traffic on both instances.
        fork
            run_fetch(0, 40);
            run_data(0, 40);
            run_fetch(1, 30);
            run_data(1, 30);
        join
        repeat (6) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("k%0d fetch queue drained", k), iq[k].size(), 0);
            check($sformatf("k%0d data queue drained", k), dq[k].size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
